// File: rtl/bypass_reg_master_if.sv
// Command, response and BRAM port bundle for the bypass register master.
// master: DUT view (accepts commands, returns responses, drives BRAM); slave: host/responder view.
interface bypass_reg_master_if;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [1:0]   cmd_op;
    logic [5:0]   cmd_idx;
    logic [511:0] cmd_data;
    logic [511:0] cmd_mask;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [511:0] rsp_data;
    logic [1:0]   rsp_status;
    logic         bram_en_a;
    logic         bram_we_a;
    logic [15:0]  bram_addr_a;
    logic [511:0] bram_wrdata_a;
    logic [511:0] bram_rddata_a;
    logic         busy;

    modport master (
        input  cmd_valid, cmd_op, cmd_idx, cmd_data, cmd_mask,
        output cmd_ready,
        output rsp_valid, rsp_data, rsp_status,
        input  rsp_ready,
        output bram_en_a, bram_we_a, bram_addr_a, bram_wrdata_a,
        input  bram_rddata_a,
        output busy
    );

    modport slave (
        output cmd_valid, cmd_op, cmd_idx, cmd_data, cmd_mask,
        input  cmd_ready,
        input  rsp_valid, rsp_data, rsp_status,
        output rsp_ready,
        input  bram_en_a, bram_we_a, bram_addr_a, bram_wrdata_a,
        output bram_rddata_a,
        input  busy
    );
endinterface

// File: rtl/bypass_reg_master.sv
// Initiator for the 512-bit bypass register BRAM port: turns read/write/poll
// commands into spaced BRAM strobes and returns one response per command.
// Ports: user_clk, user_reset (async, active-high), bus (bypass_reg_master_if.master).
module bypass_reg_master #(
    parameter int RD_LATENCY  = 2,
    parameter int POLL_MAX    = 1024,
    parameter int POLL_GAP    = 4,
    parameter int STATUS_BASE = 32
) (
    input logic                    user_clk,
    input logic                    user_reset,
    bypass_reg_master_if.master    bus
);

    localparam int PW = $clog2(POLL_MAX) + 1;
    localparam int TW = $clog2(RD_LATENCY + POLL_GAP + 1) + 1;

    localparam logic [1:0] OP_RD   = 2'b00;
    localparam logic [1:0] OP_WR   = 2'b01;
    localparam logic [1:0] OP_POLL = 2'b10;

    localparam logic [1:0] ST_OK      = 2'b00;
    localparam logic [1:0] ST_ERR_RO  = 2'b01;
    localparam logic [1:0] ST_TIMEOUT = 2'b10;
    localparam logic [1:0] ST_ERR_OP  = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_ISSUE,
        S_WR_GAP,
        S_RD_ISSUE,
        S_RD_WAIT,
        S_POLL_GAP,
        S_RSP
    } state_t;

    state_t         state;
    logic           c_poll;
    logic [511:0]   c_data;
    logic [511:0]   c_mask;
    logic [PW-1:0]  pcnt;
    logic [TW-1:0]  tcnt;

    logic           cmd_ready_q;
    logic           rsp_valid_q;
    logic [511:0]   rsp_data_q;
    logic [1:0]     rsp_status_q;
    logic           en_q;
    logic           we_q;
    logic [15:0]    addr_q;
    logic [511:0]   wrdata_q;
    logic           busy_q;

    logic           hit;
    logic           ro;
    logic [PW-1:0]  pcnt_nx;

    assign hit     = ((bus.bram_rddata_a ^ c_data) & c_mask) == '0;
    assign ro      = {1'b0, bus.cmd_idx} >= 7'(STATUS_BASE);
    assign pcnt_nx = pcnt + 1'b1;

    assign bus.cmd_ready     = cmd_ready_q;
    assign bus.rsp_valid     = rsp_valid_q;
    assign bus.rsp_data      = rsp_data_q;
    assign bus.rsp_status    = rsp_status_q;
    assign bus.bram_en_a     = en_q;
    assign bus.bram_we_a     = we_q;
    assign bus.bram_addr_a   = addr_q;
    assign bus.bram_wrdata_a = wrdata_q;
    assign bus.busy          = busy_q;

    always_ff @(posedge user_clk or posedge user_reset) begin
        if (user_reset) begin
            state        <= S_IDLE;
            c_poll       <= 1'b0;
            c_data       <= '0;
            c_mask       <= '0;
            pcnt         <= '0;
            tcnt         <= '0;
            cmd_ready_q  <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_data_q   <= '0;
            rsp_status_q <= '0;
            en_q         <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wrdata_q     <= '0;
            busy_q       <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.cmd_valid && cmd_ready_q) begin
                        cmd_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        c_poll      <= bus.cmd_op == OP_POLL;
                        c_data      <= bus.cmd_data;
                        c_mask      <= bus.cmd_mask;
                        pcnt        <= '0;
                        if (bus.cmd_op == ST_ERR_OP) begin
                            rsp_valid_q  <= 1'b1;
                            rsp_data_q   <= '0;
                            rsp_status_q <= ST_ERR_OP;
                            state        <= S_RSP;
                        end else if (bus.cmd_op == OP_WR && ro) begin
                            rsp_valid_q  <= 1'b1;
                            rsp_data_q   <= '0;
                            rsp_status_q <= ST_ERR_RO;
                            state        <= S_RSP;
                        end else if (bus.cmd_op == OP_WR) begin
                            en_q     <= 1'b1;
                            we_q     <= 1'b1;
                            addr_q   <= {4'b0, bus.cmd_idx, 6'b0};
                            wrdata_q <= bus.cmd_data;
                            state    <= S_WR_ISSUE;
                        end else begin
                            en_q   <= 1'b1;
                            we_q   <= 1'b0;
                            addr_q <= {4'b0, bus.cmd_idx, 6'b0};
                            state  <= S_RD_ISSUE;
                        end
                    end else begin
                        cmd_ready_q <= 1'b1;
                    end
                end
                S_WR_ISSUE: begin
                    en_q  <= 1'b0;
                    we_q  <= 1'b0;
                    state <= S_WR_GAP;
                end
                // Dead cycle lets the responder finish its two-cycle write.
                S_WR_GAP: begin
                    rsp_valid_q  <= 1'b1;
                    rsp_data_q   <= '0;
                    rsp_status_q <= ST_OK;
                    state        <= S_RSP;
                end
                S_RD_ISSUE: begin
                    en_q  <= 1'b0;
                    tcnt  <= TW'(1);
                    state <= S_RD_WAIT;
                end
                // tcnt counts cycles after the strobe; data is live at RD_LATENCY.
                S_RD_WAIT: begin
                    if (tcnt == TW'(RD_LATENCY)) begin
                        if (!c_poll || hit) begin
                            rsp_valid_q  <= 1'b1;
                            rsp_data_q   <= bus.bram_rddata_a;
                            rsp_status_q <= ST_OK;
                            state        <= S_RSP;
                        end else if (pcnt_nx == PW'(POLL_MAX)) begin
                            rsp_valid_q  <= 1'b1;
                            rsp_data_q   <= bus.bram_rddata_a;
                            rsp_status_q <= ST_TIMEOUT;
                            state        <= S_RSP;
                        end else begin
                            pcnt  <= pcnt_nx;
                            tcnt  <= TW'(1);
                            state <= S_POLL_GAP;
                        end
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                S_POLL_GAP: begin
                    if (tcnt == TW'(POLL_GAP)) begin
                        en_q  <= 1'b1;
                        we_q  <= 1'b0;
                        state <= S_RD_ISSUE;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                S_RSP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        busy_q      <= 1'b0;
                        state       <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/bypass_reg_master.md
Name: bypass_reg_master

Overview:
- Initiator for the 512-bit bypass register BRAM port.
- Converts a valid/ready command stream (read, write, poll) into correctly spaced bram_en/bram_we pulses, captures read data at the responder's fixed latency, and returns one response per command.
- Sits between the host-side command path and the bypass register-file responder.
- Registers 0..31 are control (R/W); registers 32..63 are status (read-only).

Parameters:
- RD_LATENCY, 2: cycles from the request cycle to the cycle in which bram_rddata_a is valid.
- POLL_MAX, 1024: maximum poll reads before a timeout.
- POLL_GAP, 4: idle cycles between consecutive poll reads.
- STATUS_BASE, 32: first read-only register index.

Ports:
- user_clk  in  1  clock.
- user_reset  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command valid.
- cmd_ready  out  1  command accepted when valid&ready.
- cmd_op  in  2  00 read, 01 write, 10 poll, 11 reserved.
- cmd_idx  in  6  register index.
- cmd_data  in  512  write data, or poll match value.
- cmd_mask  in  512  poll compare mask.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumed when valid&ready.
- rsp_data  out  512  read/poll data (0 for writes and errors).
- rsp_status  out  2  00 OK, 01 ERR_RO, 10 POLL_TIMEOUT, 11 ERR_OP.
- bram_en_a  out  1  request strobe.
- bram_we_a  out  1  1 write, 0 read.
- bram_addr_a  out  16  byte address {4'b0, idx, 6'b0}.
- bram_wrdata_a  out  512  write data.
- bram_rddata_a  in  512  read data.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset values: all outputs 0, state IDLE. Reset is asynchronous and may occur mid-operation; it aborts any transaction and drops any pending response.
- cmd_ready is 1 only in IDLE. The command is registered on acceptance.
- States: IDLE, WR_ISSUE, WR_GAP, RD_ISSUE, RD_WAIT, POLL_GAP, RSP.
- IDLE, on accept:
  - op=11 -> RSP with ERR_OP.
  - write with idx>=STATUS_BASE -> RSP with ERR_RO; no bram_en_a is issued.
  - write -> WR_ISSUE.
  - read or poll -> RD_ISSUE; poll counter cleared.
- WR_ISSUE:
  - Drives bram_en_a=1, bram_we_a=1, addr and wrdata for exactly one cycle.
  - -> WR_GAP: one cycle with en=0, required by the responder's two-cycle write handling.
  - -> RSP with status OK, data 0.
- RD_ISSUE:
  - Drives en=1, we=0, addr for exactly one cycle (cycle T).
  - -> RD_WAIT. bram_rddata_a is captured at the clock edge ending cycle T+RD_LATENCY; en stays 0 throughout.
  - read -> RSP with status OK and the captured data.
  - poll, ((data ^ cmd_data) & cmd_mask)==0 -> RSP with status OK and the captured data.
  - poll, counter+1 == POLL_MAX -> RSP with POLL_TIMEOUT and the last data.
  - otherwise the counter increments -> POLL_GAP, which waits POLL_GAP cycles -> RD_ISSUE.
- Poll against an all-zero mask succeeds on the first read.
- RSP:
  - rsp_valid=1; data and status are held stable until rsp_ready.
  - On the handshake -> IDLE.
  - cmd_ready stays 0 during RSP, so there is no command/response overlap.
- bram_en_a is never high on two consecutive cycles. Maximum throughput is one write per 3 cycles (plus the response handshake) and one read per RD_LATENCY+2 cycles.
- bram_wrdata_a and bram_addr_a hold their last values when en=0. bram_we_a is 0 whenever en=0.
- The poll counter width is clog2(POLL_MAX)+1. POLL_MAX=1 degenerates to a single read.

Test Plan:
- Write idx 3 with 0xA5A5 (zero-extended), then read idx 3 against a behavioural responder. Required:
  - write: en/we high for one cycle at addr 0x00C0, then OK response with data 0;
  - read: en high for one cycle, response data 0xA5A5 captured at T+2, status OK.
- Write idx 40 -> no bram_en_a pulse; response ERR_RO with data 0. Then op=11 -> ERR_OP.
- Poll idx 33, mask 0x1, match 0x1. The responder's status bit0 rises after the 3rd read. Required:
  - exactly 3 read strobes, spaced POLL_GAP+RD_LATENCY+1 cycles apart;
  - response OK with data bit0=1.
- Poll with POLL_MAX=8 and a never-matching value -> exactly 8 reads, then POLL_TIMEOUT with the last data.
- Hold rsp_ready low for 10 cycles after a read -> rsp_valid, data and status stable; cmd_ready=0; no bram_en_a activity. Release -> IDLE, next command accepted.
- Assert user_reset in RD_WAIT -> outputs 0 immediately (asynchronously); no response afterwards; next command behaves normally.
